fetch_sequencer: RTL
====================

# fetch_sequencer

Multi-cycle instruction sequencer for the tiny RISC-V core. It owns the program counter and fetches one instruction at a time over a valid/ready memory port. It hands each instruction to decode and waits for execute to finish before computing the next PC: sequential, or branch-relative with the immediate in half-word units. It replaces a free-running PC register for the non-pipelined core and adds fault detection and a retired-instruction counter.

## Interface
Parameters:
- ADDRESS_WIDTH, 32, width of program counter and fetch address
- COUNT_WIDTH, 32, width of retired-instruction counter

Ports:
- clock  input  1  sole clock; all state updates on rising edge
- reset_n  input  1  synchronous, active-low reset
- fetch_request_valid  output  1  fetch address valid
- fetch_request_ready  input  1  memory accepts the request
- fetch_request_address  output  ADDRESS_WIDTH  byte address of the fetch, always equal to program_counter
- fetch_response_valid  input  1  instruction word returned
- fetch_response_data  input  32  instruction word
- instruction_valid  output  1  instruction presented to decode
- instruction_ready  input  1  decode accepts the instruction
- instruction  output  32  latched instruction word
- program_counter  output  ADDRESS_WIDTH  address of the current instruction
- program_counter_plus_4  output  ADDRESS_WIDTH  program_counter + 4, modulo 2^ADDRESS_WIDTH, combinational
- execute_done  input  1  execute has completed the current instruction
- branch_taken  input  1  qualified by execute_done; take the relative target
- branch_immediate  input  32  signed immediate in half-words, qualified by execute_done
- fault  output  1  sticky misaligned-target fault
- retired_count  output  COUNT_WIDTH  instructions completed since reset

## Operation
- States: IDLE, REQUEST, WAIT, ISSUE, EXECUTE, FAULT.
- IDLE is entered only by reset. It moves to REQUEST on the next clock unconditionally.
- **REQUEST**
  - fetch_request_valid=1 with address=program_counter.
  - Valid and address stay stable until fetch_request_ready.
  - On ready, go to WAIT.
- **WAIT**
  - On fetch_response_valid, latch fetch_response_data into instruction and go to ISSUE.
  - fetch_response_valid is ignored in every other state.
- **ISSUE**
  - instruction_valid=1; instruction stays stable.
  - On instruction_ready, go to EXECUTE.
- **EXECUTE**
  - Wait for execute_done; branch_taken and branch_immediate are sampled only in the execute_done cycle.
  - Next PC:
    - taken: program_counter + (branch_immediate << 1), computed at 32 bits, truncated to ADDRESS_WIDTH, modulo wrap.
    - not taken: program_counter_plus_4, which wraps at the top of the address space.
  - If next_pc[1:0] == 0: program_counter <= next_pc, retired_count += 1 (wraps modulo 2^COUNT_WIDTH), go to REQUEST.
  - If next_pc[1:0] != 0: go to FAULT, set fault=1. program_counter and retired_count are unchanged.
- **FAULT**
  - Terminal state; all handshake outputs are 0.
  - Only reset_n low leaves FAULT.
- execute_done in any state other than EXECUTE is ignored.

## Timing
- Reset: reset_n is sampled low at a rising edge.
  - Next cycle: state=IDLE, program_counter=0, instruction=0, fetch_request_valid=0, instruction_valid=0, fault=0, retired_count=0.
  - Reset overrides any state, including mid-handshake. An outstanding memory response after reset is ignored unless state is WAIT.
- Outputs are registered, except fetch_request_address and program_counter_plus_4, which derive combinationally from the program_counter register.
- First fetch: fetch_request_valid rises in the 2nd cycle after reset_n is sampled high (one IDLE cycle).
- Minimum loop, with ready, response, instruction_ready and execute_done each arriving in the first possible cycle: 4 cycles per instruction (REQUEST, WAIT, ISSUE, EXECUTE).
- Per-state timing:
  - REQUEST: transitions at the edge where ready is high.
  - WAIT: the response may arrive in the first WAIT cycle; instruction is valid in the following cycle.
  - ISSUE: instruction_valid rises the cycle after the response is captured and drops the cycle after the handshake.
  - EXECUTE: program_counter and retired_count update at the edge that samples execute_done; fetch_request_valid is high in the next cycle.
- Handshakes complete only when valid and ready are high at the same edge. Ready high while valid is low has no effect.

## Test plan
- **Reset and sequential run:** reset, then respond to every fetch within 1 cycle, execute_done with branch_taken=0 → fetch addresses 0x0, 0x4, 0x8, 0xC; retired_count=4 after the 4th done; 4 cycles per instruction.
- **Backpressure:** hold fetch_request_ready low 3 cycles and instruction_ready low 2 cycles → valid and address/instruction stay stable throughout, with no duplicate fetch.
- **Taken branch:** at PC=0x10, branch_immediate=0xFFFFFFF8 taken → next fetch at 0x0; with immediate=0x6 → next fetch at 0x1C.
- **Misaligned target:** at PC=0x8, immediate=0x1 taken → fault=1 next cycle, program_counter stays 0x8, retired_count unchanged, no further fetch_request_valid despite continued ready.
- **Wrap-around:** force PC to 0xFFFFFFFC via branches (imm=-2 from 0x0), not-taken completion → next fetch at 0x0.
- **Reset mid-operation:** assert reset_n low during WAIT and again in FAULT → all outputs return to reset values; a late fetch_response_valid during IDLE is ignored; the first fetch is at 0x0.

Source files
------------

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: multi-cycle instruction sequencer for the non-pipelined core.
// Owns the program counter, fetches one instruction at a time, presents it to
// decode, then waits for execute before stepping or branching the PC.
// A misaligned next PC parks the block in a terminal FAULT state.
//
// Handshake rule for every valid/ready pair on this block: a transfer happens
// only at a rising edge where valid and ready are both high; valid, address and
// payload hold steady until that edge, and ready while valid is low is ignored.

module fetch_sequencer #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int COUNT_WIDTH   = 32
) (
  input  logic                     clock,
  input  logic                     reset_n,
  output logic                     fetch_request_valid,
  input  logic                     fetch_request_ready,
  output logic [ADDRESS_WIDTH-1:0] fetch_request_address,
  input  logic                     fetch_response_valid,
  input  logic [31:0]              fetch_response_data,
  output logic                     instruction_valid,
  input  logic                     instruction_ready,
  output logic [31:0]              instruction,
  output logic [ADDRESS_WIDTH-1:0] program_counter,
  output logic [ADDRESS_WIDTH-1:0] program_counter_plus_4,
  input  logic                     execute_done,
  input  logic                     branch_taken,
  input  logic [31:0]              branch_immediate,
  output logic                     fault,
  output logic [COUNT_WIDTH-1:0]   retired_count,
  output logic [2:0]               debug_state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_REQUEST = 3'd1,
    S_WAIT    = 3'd2,
    S_ISSUE   = 3'd3,
    S_EXECUTE = 3'd4,
    S_FAULT   = 3'd5
  } state_t;

  state_t                   r_state;
  state_t                   w_next_state;

  logic [ADDRESS_WIDTH-1:0] r_pc;
  logic [31:0]              r_instruction;
  logic [COUNT_WIDTH-1:0]   r_retired;
  logic                     r_fetch_valid;
  logic                     r_instr_valid;
  logic                     r_fault;

  logic [ADDRESS_WIDTH-1:0] w_pc_plus_4;
  logic [31:0]              w_imm_bytes;
  logic [31:0]              w_branch_sum;
  logic [ADDRESS_WIDTH-1:0] w_branch_target;
  logic [ADDRESS_WIDTH-1:0] w_next_pc;
  logic                     w_next_aligned;
  logic                     w_retire;
  logic                     w_capture;
  logic                     w_fetch_valid_nxt;
  logic                     w_instr_valid_nxt;
  logic                     w_fault_nxt;

  // Next-PC datapath: the branch sum is formed at 32 bits and then truncated
  // to the address width, so both paths wrap at the top of the address space.
  assign w_pc_plus_4     = r_pc + ADDRESS_WIDTH'(4);
  assign w_imm_bytes     = branch_immediate << 1;
  assign w_branch_sum    = 32'(r_pc) + w_imm_bytes;
  assign w_branch_target = ADDRESS_WIDTH'(w_branch_sum);
  assign w_next_pc       = branch_taken ? w_branch_target : w_pc_plus_4;
  assign w_next_aligned  = (w_next_pc[1:0] == 2'b00);

  // Update strobes; inputs are only meaningful in their owning state.
  assign w_retire  = (r_state == S_EXECUTE) && execute_done && w_next_aligned;
  assign w_capture = (r_state == S_WAIT) && fetch_response_valid;

  // State register with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic: walk request -> wait -> issue -> execute, or stop in FAULT.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:    w_next_state = S_REQUEST;
      S_REQUEST: if (fetch_request_ready)  w_next_state = S_WAIT;
      S_WAIT:    if (fetch_response_valid) w_next_state = S_ISSUE;
      S_ISSUE:   if (instruction_ready)    w_next_state = S_EXECUTE;
      S_EXECUTE: begin
        if (execute_done) begin
          w_next_state = w_next_aligned ? S_REQUEST : S_FAULT;
        end
      end
      S_FAULT:   w_next_state = S_FAULT;
      default:   w_next_state = S_IDLE;
    endcase
  end

  // Output decode from the next state so the handshake outputs come out of flops.
  always_comb begin
    w_fetch_valid_nxt = 1'b0;
    w_instr_valid_nxt = 1'b0;
    w_fault_nxt       = 1'b0;
    case (w_next_state)
      S_REQUEST: w_fetch_valid_nxt = 1'b1;
      S_ISSUE:   w_instr_valid_nxt = 1'b1;
      S_FAULT:   w_fault_nxt       = 1'b1;
      default: begin
        w_fetch_valid_nxt = 1'b0;
        w_instr_valid_nxt = 1'b0;
        w_fault_nxt       = 1'b0;
      end
    endcase
  end

  // Registered handshake and fault outputs.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_fetch_valid <= 1'b0;
      r_instr_valid <= 1'b0;
      r_fault       <= 1'b0;
    end else begin
      r_fetch_valid <= w_fetch_valid_nxt;
      r_instr_valid <= w_instr_valid_nxt;
      r_fault       <= w_fault_nxt;
    end
  end

  // Instruction latch: loaded only by a response that arrives while waiting.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_instruction <= 32'd0;
    end else if (w_capture) begin
      r_instruction <= fetch_response_data;
    end
  end

  // PC and retired counter advance together on an aligned completion only.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_pc      <= '0;
      r_retired <= '0;
    end else if (w_retire) begin
      r_pc      <= w_next_pc;
      r_retired <= r_retired + COUNT_WIDTH'(1);
    end
  end

  assign fetch_request_valid    = r_fetch_valid;
  assign fetch_request_address  = r_pc;
  assign instruction_valid      = r_instr_valid;
  assign instruction            = r_instruction;
  assign program_counter        = r_pc;
  assign program_counter_plus_4 = w_pc_plus_4;
  assign fault                  = r_fault;
  assign retired_count          = r_retired;
  assign debug_state            = r_state;

endmodule
